// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache between a 10-bit CPU and a 20-bit two-word-block RAM
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata : CPU request, sampled only while idle
//   cpu_rdata/done/busy   : read data (held), one-cycle completion pulse, busy flag
//   mem_req/we/addr       : registered RAM request, write enable, address
//   mem_data              : shared RAM bus {odd word, even word}, driven here only while writing
//   mem_ready             : RAM idle flag
//   hit_count/miss_count  : saturating read hit/miss counters
module cache_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 9 - INDEX_BITS,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [9:0]       cpu_addr,
    input  logic [9:0]       cpu_wdata,
    output logic [9:0]       cpu_rdata,
    output logic             cpu_done,
    output logic             cpu_busy,
    output logic             mem_req,
    output logic             mem_we,
    output logic [9:0]       mem_addr,
    inout  wire  [19:0]      mem_data,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int LINES = 1 << INDEX_BITS;
    typedef enum logic [2:0] {IDLE, TAG, MREQ, MLO, MHI} state_t;
    state_t                r_state;
    logic                  r_we;
    logic [9:0]            r_addr;
    logic [9:0]            r_wdata;
    logic [LINES-1:0]      r_valid;
    logic [19:0]           r_data [LINES];
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [9:0]            r_rdata;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [9:0]            r_mem_addr;
    logic [CNT_W-1:0]      r_hits;
    logic [CNT_W-1:0]      r_misses;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic [19:0]           w_line;
    logic                  w_hit;
    logic                  w_fill;
    logic                  w_wupd;
    assign w_idx  = r_addr[INDEX_BITS:1];
    assign w_tag  = r_addr[9:INDEX_BITS+1];
    assign w_line = r_data[w_idx];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill = (r_state == MHI) && mem_ready && !r_we;
    assign w_wupd = (r_state == TAG) && r_we && w_hit;
    // r_mem_we is high only during MREQ, so the bus is released in every other cycle
    assign mem_data   = r_mem_we ? {r_wdata, r_wdata} : 20'bz;
    assign cpu_rdata  = r_rdata;
    assign cpu_done   = r_done;
    assign cpu_busy   = r_busy;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign hit_count  = r_hits;
    assign miss_count = r_misses;
    // Line storage needs no reset; the valid bits guard it
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_idx] <= mem_data;
            r_tag[w_idx]  <= w_tag;
        end else if (w_wupd) begin
            r_data[w_idx] <= r_addr[0] ? {r_wdata, w_line[9:0]} : {w_line[19:10], r_wdata};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_valid    <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_hits     <= '0;
            r_misses   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_fill)
                r_valid[w_idx] <= 1'b1;
            case (r_state)
                IDLE: if (cpu_req) begin
                    r_we    <= cpu_we;
                    r_addr  <= cpu_addr;
                    r_wdata <= cpu_wdata;
                    r_busy  <= 1'b1;
                    r_state <= TAG;
                end
                TAG: if (!r_we && w_hit) begin
                    r_rdata <= r_addr[0] ? w_line[19:10] : w_line[9:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    if (~&r_hits)
                        r_hits <= r_hits + 1'b1;
                    r_state <= IDLE;
                end else begin
                    if (!r_we && ~&r_misses)
                        r_misses <= r_misses + 1'b1;
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= r_we;
                    r_mem_addr <= r_addr;
                    r_state    <= MREQ;
                end
                MREQ: begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_state   <= MLO;
                end
                // ready seen during MREQ is stale; wait for the RAM to go busy first
                MLO: if (!mem_ready)
                    r_state <= MHI;
                MHI: if (mem_ready) begin
                    if (!r_we)
                        r_rdata <= r_addr[0] ? mem_data[19:10] : mem_data[9:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: scoreboard bench for cache_ctrl with a two-cycle block RAM model
module tb_cache_ctrl;
    typedef struct {
        logic [9:0]  rd;
        int          req_cyc;
        int          lat;
        int          n_req;
        logic [9:0]  addr;
        logic        we;
        logic [19:0] md;
        logic [15:0] hits;
        logic [15:0] misses;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [9:0]  cpu_wdata = '0;
    logic [9:0]  cpu_rdata;
    logic        cpu_done;
    logic        cpu_busy;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    wire  [19:0] mem_data;
    logic        mem_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [19:0] ram [512];
    logic [19:0] r_rd;
    logic        r_drv;
    exp_t        exp_q [$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          done_n = 0;
    int          rst_req = 0;
    int          rst_done = 0;
    int          eh = 0;
    int          em = 0;
    cache_ctrl #(.INDEX_BITS(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_busy(cpu_busy), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // RAM presents read data for the one cycle after completion only
    assign mem_data = (!mem_we && r_drv) ? r_rd : 20'bz;
    // Block b holds {2*b, b}: even word = b, odd word = 2*b
    initial begin
        int cnt;
        logic [9:0] la;
        logic lwe;
        logic [19:0] ld;
        for (int b = 0; b < 512; b++) ram[b] = {10'(2 * b), 10'(b)};
        mem_ready <= 1'b1;
        r_drv <= 1'b0;
        r_rd <= '0;
        cnt = 0;
        forever begin
            @(posedge clk);
            r_drv <= 1'b0;
            if (cnt == 0) begin
                if (mem_req === 1'b1) begin
                    la = mem_addr;
                    lwe = mem_we;
                    ld = mem_data;
                    cnt = 2;
                    mem_ready <= 1'b0;
                end
            end else begin
                cnt--;
                if (cnt == 0) begin
                    if (lwe) begin
                        if (la[0]) ram[la[9:1]][19:10] = ld[19:10];
                        else ram[la[9:1]][9:0] = ld[9:0];
                    end else begin
                        r_rd <= ram[la[9:1]];
                        r_drv <= 1'b1;
                    end
                    mem_ready <= 1'b1;
                end
            end
        end
    end
    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, want, cyc);
        end
    endfunction
    // Monitor: observes the RAM side continuously, scores each cpu_done against the queue head
    initial begin
        int n_req = 0;
        int n_we = 0;
        bit zf = 0;
        bit prev_req = 0;
        bit tmo;
        logic [9:0] req_addr = '0;
        logic [19:0] req_data = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n_req = 0;
                n_we = 0;
                zf = 0;
                prev_req = 0;
                if (rst_req != rst_done) begin
                    rst_done = rst_req;
                    chk("rst_done", 32'(cpu_done), 0);
                    chk("rst_busy", 32'(cpu_busy), 0);
                    chk("rst_mem_req", 32'(mem_req), 0);
                    chk("rst_mem_we", 32'(mem_we), 0);
                    chk("rst_mem_addr", 32'(mem_addr), 0);
                    chk("rst_rdata", 32'(cpu_rdata), 0);
                    chk("rst_hits", 32'(hit_count), 0);
                    chk("rst_misses", 32'(miss_count), 0);
                    chk("rst_bus_z", 32'(mem_data === 20'bz), 1);
                end
            end else begin
                if (prev_req && !mem_req) zf = (mem_data === 20'bz);
                prev_req = mem_req;
                if (mem_req) begin
                    n_req++;
                    req_addr = mem_addr;
                    req_data = mem_data;
                end
                if (mem_we) n_we++;
                if (cpu_done === 1'b1) begin
                    done_n++;
                    chk("done_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rdata", 32'(cpu_rdata), 32'(e.rd));
                        chk("busy_at_done", 32'(cpu_busy), 0);
                        if (e.lat != 0) chk("hit_latency", 32'(cyc - e.req_cyc), 32'(e.lat));
                        chk("mem_req_cycles", 32'(n_req), 32'(e.n_req));
                        if (e.n_req != 0) begin
                            chk("mem_addr", 32'(req_addr), 32'(e.addr));
                            chk("bus_z_after_req", 32'(zf), 1);
                        end
                        chk("mem_we_cycles", 32'(n_we), 32'(e.we));
                        if (e.we) chk("mem_wdata", 32'(req_data), 32'(e.md));
                        chk("hit_count", 32'(hit_count), 32'(e.hits));
                        chk("miss_count", 32'(miss_count), 32'(e.misses));
                    end
                    n_req = 0;
                    n_we = 0;
                    zf = 0;
                end else if (exp_q.size() != 0) begin
                    tmo = (cyc - exp_q[0].req_cyc) > 40;
                    if (tmo) begin
                        chk("done_timeout", 32'(tmo), 0);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end
    task automatic do_reset();
        rst_n = 1'b0;
        rst_req++;
        eh = 0;
        em = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic xact(input logic we, input logic [9:0] a, input logic [9:0] wd,
                        input logic [9:0] rd, input bit hit);
        exp_t e;
        int d0;
        @(negedge clk);
        if (!we) begin
            if (hit) eh++;
            else em++;
        end
        e.rd = rd;
        e.req_cyc = cyc;
        e.lat = (hit && !we) ? 2 : 0;
        e.n_req = (hit && !we) ? 0 : 1;
        e.addr = a;
        e.we = we;
        e.md = {wd, wd};
        e.hits = 16'(eh);
        e.misses = 16'(em);
        exp_q.push_back(e);
        d0 = done_n;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (done_n != d0) break;
            @(negedge clk);
        end
    endtask
    initial begin
        #1;
        do_reset();
        xact(0, 10'd10, 10'h000, 10'h005, 0);
        xact(0, 10'd11, 10'h000, 10'h00A, 1);
        xact(1, 10'd11, 10'h155, 10'h00A, 1);
        xact(0, 10'd11, 10'h000, 10'h155, 1);
        xact(1, 10'd300, 10'h0AA, 10'h155, 0);
        xact(0, 10'd300, 10'h000, 10'h0AA, 0);
        do_reset();
        xact(0, 10'd10, 10'h000, 10'h005, 0);
        xact(0, 10'd42, 10'h000, 10'h015, 0);
        xact(0, 10'd10, 10'h000, 10'h005, 0);
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 10'd20;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 10 && !mem_ready; i++) @(negedge clk);
        xact(0, 10'd20, 10'h000, 10'h00A, 0);
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller between the 10-bit CPU datapath and the 20-bit two-word-block RAM.
- Serves CPU word reads from a local line array.
- Fills on read misses using the RAM's mem_req/mem_ready handshake.
- Forwards every write to RAM.
- Owns the RAM side of the shared inout data bus.

Parameters:
- INDEX_BITS, 4, line index width; LINES = 2^INDEX_BITS lines, each holding 2 x 10-bit words.
- TAG_BITS, 9-INDEX_BITS, tag width; derived, do not override.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  single-cycle request pulse; sampled only while cpu_busy=0.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  10  word address.
- cpu_wdata  in  10  write data.
- cpu_rdata  out  10  read data; valid while cpu_done=1, held until the next read completes.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high from the cycle after acceptance until cpu_done.
- mem_req  out  1  RAM request, registered.
- mem_we  out  1  RAM write enable.
- mem_addr  out  10  RAM address.
- mem_data  inout  20  RAM data bus ({odd word, even word}).
- mem_ready  in  1  RAM ready; high when RAM is idle.
- hit_count  out  CNT_W  read hits, saturating.
- miss_count  out  CNT_W  read misses, saturating.

Behaviour:
- Address split: tag = cpu_addr[9:INDEX_BITS+1]; index = cpu_addr[INDEX_BITS:1]; word select = cpu_addr[0].
- Reset (async, rst_n=0):
  - state=IDLE; all valid bits cleared.
  - cpu_rdata, cpu_done, cpu_busy, mem_req, mem_we, mem_addr, hit_count, miss_count all 0.
  - mem_data released (Z).
  - Reset mid-transaction abandons the transaction with no cpu_done.
- State machine: IDLE, TAG, MREQ, MLO, MHI.
  - IDLE: cpu_req=1 latches we/addr/wdata, sets cpu_busy, goes to TAG. cpu_req while busy is ignored.
  - TAG:
    - Read hit (valid and tag equal): cpu_rdata <= selected word; cpu_done=1 for the next cycle; hit_count+1; go to IDLE. Request edge to cpu_done high is 2 cycles.
    - Read miss: miss_count+1, go to MREQ.
    - Write, hit or miss: if hit, update the cached word in place; go to MREQ. Write misses never allocate.
  - MREQ (exactly one cycle): mem_req=1, mem_addr=latched addr, mem_we=latched we. For writes, drive mem_data={wdata,wdata}; the RAM picks the half from addr[0]. Go to MLO.
  - MLO: mem_req=0, mem_we=0, bus released. Wait for mem_ready=0, then go to MHI. Do not exit on the stale ready seen during MREQ.
  - MHI: hold mem_addr. Wait for mem_ready=1. On that edge:
    - Read: line[index] <= mem_data, tag stored, valid set; cpu_rdata <= mem_data[19:10] if addr[0]=1, else mem_data[9:0].
    - Both reads and writes: cpu_done=1, cpu_busy cleared, go to IDLE.
- Bus ownership: mem_data is driven only in MREQ with mem_we=1; Z in every other cycle. mem_we is 0 outside MREQ, because the RAM drives the bus whenever it is not (idle and write).
- Miss latency with the standard 2-cycle RAM: request edge to cpu_done is about 5-6 cycles. Exact count is set by the mem_ready edges, not fixed.
- Counters saturate at all-ones; writes do not count.
- Back-to-back requests: a new cpu_req is accepted in the same cycle cpu_done is high (state is IDLE).
- Write followed by a read of the same address returns the new data, whether the line is cached or refilled.

Test Plan:
- Reset, then read addr 10 -> miss: mem_req one pulse with mem_addr=10; after mem_ready rises, cpu_rdata=0x005, cpu_done one cycle; miss_count=1.
- Read addr 11 next -> hit, no mem_req, cpu_rdata=0x00A exactly 2 cycles after cpu_req; hit_count=1.
- Write 0x155 to addr 11 (cached) -> mem_data=0x55555 only during the MREQ cycle, mem_we=1 only that cycle; a later read of 11 hits and returns 0x155.
- Write 0x0AA to uncached addr 300, then read 300 -> write issues no fill; the read misses and refills with 0x0AA in the low word.
- Conflict: read 10, then read 10+2^(INDEX_BITS+1)=42 (same index, different tag), then read 10 -> miss, miss, miss; miss_count=3.
- Assert rst_n=0 during MLO of a miss -> mem_req=0, bus Z, cpu_busy=0, no cpu_done; a re-read of the same address misses.
